// File: rtl/fpu_sched.sv
// fpu_sched: two-port round-robin scheduler for a shared FPU32 datapath.
// One operation in flight; result held until the consumer takes it.
module fpu_sched #(
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic        i_clk,
    input  logic        i_rsn,
    input  logic        i_req0_valid,
    input  logic        i_req1_valid,
    output logic        o_req0_ready,
    output logic        o_req1_ready,
    input  logic [1:0]  i_req0_op,
    input  logic [1:0]  i_req1_op,
    input  logic [31:0] i_req0_op1,
    input  logic [31:0] i_req0_op2,
    input  logic [31:0] i_req1_op1,
    input  logic [31:0] i_req1_op2,
    input  logic [3:0]  i_req0_tag,
    input  logic [3:0]  i_req1_tag,
    output logic [31:0] o_fpu_op1,
    output logic [31:0] o_fpu_op2,
    input  logic [31:0] i_fpu_addres,
    input  logic [31:0] i_fpu_subres,
    input  logic [31:0] i_fpu_mulres,
    input  logic [31:0] i_fpu_divres,
    output logic        o_res_valid,
    input  logic        i_res_ready,
    output logic [31:0] o_res_data,
    output logic [3:0]  o_res_tag,
    output logic        o_res_src,
    input  logic        i_flush,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] ADD_L = 4'(ADD_LAT);
    localparam logic [3:0] MUL_L = 4'(MUL_LAT);
    localparam logic [3:0] DIV_L = 4'(DIV_LAT);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    state_t      state_q;
    state_t      state_d;
    logic        ptr_q;
    logic        ptr_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        rst_q;

    logic [1:0]  op_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic [31:0] res_q;
    logic [3:0]  tag_q;
    logic        src_q;

    logic        gnt0;
    logic        gnt1;
    logic        grant;
    logic        cap_res;
    logic [1:0]  g_op;
    logic [31:0] g_op1;
    logic [31:0] g_op2;
    logic [3:0]  g_tag;
    logic [31:0] res_sel;

    function automatic logic [3:0] lat_of(input logic [1:0] op);
        logic [3:0] l;
        unique case (op)
            OP_ADD:  l = ADD_L;
            OP_SUB:  l = ADD_L;
            OP_MUL:  l = MUL_L;
            default: l = DIV_L;
        endcase
        return l;
    endfunction

    // Arbitration and next-state; grants only in IDLE, never during
    // flush, reset, or the cycle right after reset.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        cap_res = 1'b0;
        if (i_flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!i_rsn && !rst_q) begin
                        if (i_req0_valid && i_req1_valid) begin
                            gnt0 = !ptr_q;
                            gnt1 = ptr_q;
                        end else begin
                            gnt0 = i_req0_valid;
                            gnt1 = i_req1_valid;
                        end
                        if (gnt0 || gnt1) begin
                            state_d = BUSY;
                            ptr_d   = gnt0;
                            cnt_d   = lat_of(gnt1 ? i_req1_op : i_req0_op);
                        end
                    end
                end
                BUSY: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = DONE;
                        cap_res = 1'b1;
                    end
                end
                DONE: begin
                    if (i_res_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Operand/tag mux of the winning requester.
    always_comb begin
        grant = gnt0 || gnt1;
        g_op  = gnt1 ? i_req1_op  : i_req0_op;
        g_op1 = gnt1 ? i_req1_op1 : i_req0_op1;
        g_op2 = gnt1 ? i_req1_op2 : i_req0_op2;
        g_tag = gnt1 ? i_req1_tag : i_req0_tag;
    end

    // Pick the FPU result bus matching the captured op.
    always_comb begin
        res_sel = i_fpu_addres;
        unique case (1'b1)
            op_q == OP_ADD: res_sel = i_fpu_addres;
            op_q == OP_SUB: res_sel = i_fpu_subres;
            op_q == OP_MUL: res_sel = i_fpu_mulres;
            op_q == OP_DIV: res_sel = i_fpu_divres;
        endcase
    end

    // FSM state, round-robin pointer and latency counter.
    always_ff @(posedge i_clk) begin
        if (i_rsn) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Delayed reset keeps grants off for one cycle after reset.
    always_ff @(posedge i_clk) begin
        rst_q <= i_rsn;
    end

    // Captured request and registered result.
    always_ff @(posedge i_clk) begin
        if (i_rsn) begin
            op_q  <= 2'b00;
            op1_q <= 32'd0;
            op2_q <= 32'd0;
            tag_q <= 4'd0;
            src_q <= 1'b0;
            res_q <= 32'd0;
        end else begin
            if (grant) begin
                op_q  <= g_op;
                op1_q <= g_op1;
                op2_q <= g_op2;
                tag_q <= g_tag;
                src_q <= gnt1;
            end
            if (cap_res) begin
                res_q <= res_sel;
            end
        end
    end

    assign o_req0_ready = gnt0;
    assign o_req1_ready = gnt1;
    assign o_fpu_op1    = op1_q;
    assign o_fpu_op2    = op2_q;
    assign o_res_data   = res_q;
    assign o_res_tag    = tag_q;
    assign o_res_src    = src_q;
    assign o_res_valid  = (state_q == DONE) && !i_rsn;
    assign o_busy       = (state_q != IDLE) && !i_rsn;

    a_one_grant: assert property (
        @(posedge i_clk) !(o_req0_ready && o_req1_ready));

    a_flush_no_grant: assert property (
        @(posedge i_clk) i_flush |-> !(o_req0_ready || o_req1_ready));

endmodule

// File: tb/tb_fpu_sched.sv
// tb_fpu_sched: scoreboard bench for fpu_sched with a behavioural
// FPU32 stand-in driven from the scheduler's operand outputs.
module tb_fpu_sched;

    localparam int ADD_LAT = 2;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;

    logic        i_clk = 1'b0;
    logic        i_rsn;
    logic        i_req0_valid, i_req1_valid;
    logic        o_req0_ready, o_req1_ready;
    logic [1:0]  i_req0_op, i_req1_op;
    logic [31:0] i_req0_op1, i_req0_op2;
    logic [31:0] i_req1_op1, i_req1_op2;
    logic [3:0]  i_req0_tag, i_req1_tag;
    logic [31:0] o_fpu_op1, o_fpu_op2;
    logic [31:0] i_fpu_addres, i_fpu_subres;
    logic [31:0] i_fpu_mulres, i_fpu_divres;
    logic        o_res_valid;
    logic        i_res_ready;
    logic [31:0] o_res_data;
    logic [3:0]  o_res_tag;
    logic        o_res_src;
    logic        i_flush;
    logic        o_busy;

    fpu_sched #(
        .ADD_LAT(ADD_LAT),
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) dut (
        .i_clk(i_clk),
        .i_rsn(i_rsn),
        .i_req0_valid(i_req0_valid),
        .i_req1_valid(i_req1_valid),
        .o_req0_ready(o_req0_ready),
        .o_req1_ready(o_req1_ready),
        .i_req0_op(i_req0_op),
        .i_req1_op(i_req1_op),
        .i_req0_op1(i_req0_op1),
        .i_req0_op2(i_req0_op2),
        .i_req1_op1(i_req1_op1),
        .i_req1_op2(i_req1_op2),
        .i_req0_tag(i_req0_tag),
        .i_req1_tag(i_req1_tag),
        .o_fpu_op1(o_fpu_op1),
        .o_fpu_op2(o_fpu_op2),
        .i_fpu_addres(i_fpu_addres),
        .i_fpu_subres(i_fpu_subres),
        .i_fpu_mulres(i_fpu_mulres),
        .i_fpu_divres(i_fpu_divres),
        .o_res_valid(o_res_valid),
        .i_res_ready(i_res_ready),
        .o_res_data(o_res_data),
        .o_res_tag(o_res_tag),
        .o_res_src(o_res_src),
        .i_flush(i_flush),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_bad = 0;
    int n_taken = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        src;
        int          hs;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    bit   prev_v = 1'b0;

    task automatic chk(input string t, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", t, got, exp);
        end
    endtask

    function automatic logic [31:0] f_add(input logic [31:0] a, b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return a + b;
    endfunction

    function automatic logic [31:0] f_sub(input logic [31:0] a, b);
        return a - b;
    endfunction

    function automatic logic [31:0] f_mul(input logic [31:0] a, b);
        if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        return a * b;
    endfunction

    function automatic logic [31:0] f_div(input logic [31:0] a, b);
        return a ^ {b[15:0], b[31:16]};
    endfunction

    function automatic logic [31:0] f_exp(input logic [1:0] op,
                                          input logic [31:0] a, b);
        case (op)
            2'b00:   return f_add(a, b);
            2'b01:   return f_sub(a, b);
            2'b10:   return f_mul(a, b);
            default: return f_div(a, b);
        endcase
    endfunction

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'b00, 2'b01: return ADD_LAT;
            2'b10:        return MUL_LAT;
            default:      return DIV_LAT;
        endcase
    endfunction

    // FPU32 stand-in, purely combinational on the operand buses.
    always_comb begin
        i_fpu_addres = f_add(o_fpu_op1, o_fpu_op2);
        i_fpu_subres = f_sub(o_fpu_op1, o_fpu_op2);
        i_fpu_mulres = f_mul(o_fpu_op1, o_fpu_op2);
        i_fpu_divres = f_div(o_fpu_op1, o_fpu_op2);
    end

    always @(posedge i_clk) cyc++;

    // Scoreboard: push on request handshake, compare on result.
    always @(negedge i_clk) begin
        if (i_rsn || i_flush) begin
            sb.delete();
            prev_v = 1'b0;
        end else begin
            if (o_req0_ready && i_req0_valid)
                sb.push_back('{f_exp(i_req0_op, i_req0_op1, i_req0_op2),
                               i_req0_tag, 1'b0, cyc, lat_of(i_req0_op)});
            if (o_req1_ready && i_req1_valid)
                sb.push_back('{f_exp(i_req1_op, i_req1_op1, i_req1_op2),
                               i_req1_tag, 1'b1, cyc, lat_of(i_req1_op)});
            if (o_res_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_res", 32'd1, 32'd0);
                end else begin
                    e = sb[0];
                    if (!prev_v)
                        chk("latency", 32'(cyc - e.hs), 32'(e.lat + 1));
                    chk("res_data", o_res_data, e.data);
                    chk("res_tag", 32'(o_res_tag), 32'(e.tag));
                    chk("res_src", 32'(o_res_src), 32'(e.src));
                    if (i_res_ready) begin
                        void'(sb.pop_front());
                        n_taken++;
                    end
                end
            end
            prev_v = o_res_valid && !i_res_ready;
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drv(input bit p, input logic [1:0] op,
                       input logic [31:0] a, b, input logic [3:0] t);
        if (!p) begin
            i_req0_valid = 1'b1;
            i_req0_op = op;
            i_req0_op1 = a;
            i_req0_op2 = b;
            i_req0_tag = t;
        end else begin
            i_req1_valid = 1'b1;
            i_req1_op = op;
            i_req1_op1 = a;
            i_req1_op2 = b;
            i_req1_tag = t;
        end
    endtask

    task automatic wait_rdy(input bit p);
        int k;
        k = 0;
        while (k < 60) begin
            #3;
            if ((!p && o_req0_ready) || (p && o_req1_ready)) break;
            step();
            k++;
        end
        if (k >= 60) chk("rdy_timeout", 32'(p), 32'hFFFF);
    endtask

    task automatic wait_idle(input bit rnd);
        int k;
        k = 0;
        while (k < 200) begin
            if (rnd) i_res_ready = 1'($urandom_range(0, 1));
            #3;
            if (!o_busy) break;
            step();
            k++;
        end
        i_res_ready = 1'b1;
        if (k >= 200) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (k < 60) begin
            #3;
            if (o_res_valid) break;
            step();
            k++;
        end
        if (k >= 60) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int taken0;
        logic [1:0] rop;
        logic [31:0] ra, rb;
        bit rp;

        i_rsn = 1'b1;
        i_flush = 1'b0;
        i_res_ready = 1'b1;
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        i_req0_op = 2'b00;
        i_req1_op = 2'b00;
        i_req0_op1 = 32'd0;
        i_req0_op2 = 32'd0;
        i_req1_op1 = 32'd0;
        i_req1_op2 = 32'd0;
        i_req0_tag = 4'd0;
        i_req1_tag = 4'd0;

        drv(1'b0, 2'b11, 32'h41000000, 32'h40000000, 4'd1);
        drv(1'b1, 2'b11, 32'h40800000, 32'h3F800000, 4'd2);
        step();
        #3;
        chk("rst_rdy0", 32'(o_req0_ready), 32'd0);
        chk("rst_rdy1", 32'(o_req1_ready), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_valid", 32'(o_res_valid), 32'd0);
        chk("rst_data", o_res_data, 32'd0);
        chk("rst_fop1", o_fpu_op1, 32'd0);
        step();
        i_rsn = 1'b0;
        #3;
        chk("post_rst_rdy0", 32'(o_req0_ready), 32'd0);
        chk("post_rst_rdy1", 32'(o_req1_ready), 32'd0);
        chk("post_rst_busy", 32'(o_busy), 32'd0);
        step();
        #3;
        chk("both_first_rdy0", 32'(o_req0_ready), 32'd1);
        chk("both_first_rdy1", 32'(o_req1_ready), 32'd0);
        step();
        i_req0_valid = 1'b0;
        #3;
        chk("fpu_op1_t1", o_fpu_op1, 32'h41000000);
        chk("fpu_op2_t1", o_fpu_op2, 32'h40000000);
        chk("busy_rdy1", 32'(o_req1_ready), 32'd0);
        step();
        wait_rdy(1'b1);
        step();
        i_req1_valid = 1'b0;
        wait_idle(1'b0);
        chk("div_pair_taken", 32'(n_taken), 32'd2);

        step();
        drv(1'b0, 2'b00, 32'h3F800000, 32'h40000000, 4'd5);
        wait_rdy(1'b0);
        t0 = cyc;
        step();
        i_req0_valid = 1'b0;
        #3;
        chk("add_t1_valid", 32'(o_res_valid), 32'd0);
        step();
        #3;
        chk("add_t2_valid", 32'(o_res_valid), 32'd0);
        step();
        #3;
        chk("add_t3_cycle", 32'(cyc - t0), 32'd3);
        chk("add_t3_valid", 32'(o_res_valid), 32'd1);
        chk("add_t3_data", o_res_data, 32'h40400000);
        chk("add_t3_tag", 32'(o_res_tag), 32'd5);
        chk("add_t3_src", 32'(o_res_src), 32'd0);
        step();
        #3;
        chk("add_t4_busy", 32'(o_busy), 32'd0);

        step();
        i_res_ready = 1'b0;
        drv(1'b1, 2'b10, 32'h40000000, 32'h40400000, 4'd9);
        wait_rdy(1'b1);
        step();
        i_req1_valid = 1'b0;
        wait_valid();
        taken0 = n_taken;
        for (int j = 0; j < 10; j++) begin
            step();
            #3;
            chk("hold_valid", 32'(o_res_valid), 32'd1);
            chk("hold_data", o_res_data, 32'h40C00000);
        end
        step();
        i_res_ready = 1'b1;
        #3;
        step();
        #3;
        chk("hold_after_valid", 32'(o_res_valid), 32'd0);
        chk("hold_one_taken", 32'(n_taken - taken0), 32'd1);

        step();
        drv(1'b0, 2'b11, 32'h40A00000, 32'h40000000, 4'd3);
        wait_rdy(1'b0);
        step();
        i_req0_valid = 1'b0;
        drv(1'b1, 2'b00, 32'h00001234, 32'h00000011, 4'd4);
        #3;
        chk("fl_busy_rdy1", 32'(o_req1_ready), 32'd0);
        step();
        i_flush = 1'b1;
        #3;
        chk("fl_rdy0", 32'(o_req0_ready), 32'd0);
        chk("fl_rdy1", 32'(o_req1_ready), 32'd0);
        step();
        i_flush = 1'b0;
        #3;
        chk("fl_idle_busy", 32'(o_busy), 32'd0);
        chk("fl_idle_valid", 32'(o_res_valid), 32'd0);
        chk("fl_pending_rdy1", 32'(o_req1_ready), 32'd1);
        step();
        i_req1_valid = 1'b0;
        wait_idle(1'b0);

        step();
        i_res_ready = 1'b0;
        drv(1'b0, 2'b10, 32'h00000007, 32'h00000003, 4'd7);
        wait_rdy(1'b0);
        step();
        i_req0_valid = 1'b0;
        wait_valid();
        step();
        i_rsn = 1'b1;
        drv(1'b0, 2'b00, 32'h00000100, 32'h00000001, 4'd10);
        drv(1'b1, 2'b00, 32'h00000200, 32'h00000002, 4'd11);
        #3;
        chk("rd_rst_valid", 32'(o_res_valid), 32'd0);
        chk("rd_rst_busy", 32'(o_busy), 32'd0);
        chk("rd_rst_rdy0", 32'(o_req0_ready), 32'd0);
        step();
        i_rsn = 1'b0;
        #3;
        chk("rd_post_valid", 32'(o_res_valid), 32'd0);
        chk("rd_post_busy", 32'(o_busy), 32'd0);
        chk("rd_post_rdy0", 32'(o_req0_ready), 32'd0);
        chk("rd_post_fop1", o_fpu_op1, 32'd0);
        chk("rd_post_fop2", o_fpu_op2, 32'd0);
        chk("rd_post_data", o_res_data, 32'd0);
        chk("rd_post_tag", 32'(o_res_tag), 32'd0);
        chk("rd_post_src", 32'(o_res_src), 32'd0);
        step();
        #3;
        chk("rd_ptr_rdy0", 32'(o_req0_ready), 32'd1);
        chk("rd_ptr_rdy1", 32'(o_req1_ready), 32'd0);
        step();
        i_req0_valid = 1'b0;
        i_res_ready = 1'b1;
        wait_rdy(1'b1);
        step();
        i_req1_valid = 1'b0;
        wait_idle(1'b0);

        step();
        drv(1'b1, 2'b01, 32'h00005000, 32'h00000300, 4'd12);
        #3;
        chk("rr_alone_rdy1", 32'(o_req1_ready), 32'd1);
        chk("rr_alone_rdy0", 32'(o_req0_ready), 32'd0);
        step();
        i_req1_valid = 1'b0;
        wait_idle(1'b0);
        step();
        drv(1'b0, 2'b00, 32'h00000010, 32'h00000020, 4'd13);
        drv(1'b1, 2'b10, 32'h00000030, 32'h00000040, 4'd14);
        #3;
        chk("rr_both_rdy0", 32'(o_req0_ready), 32'd1);
        chk("rr_both_rdy1", 32'(o_req1_ready), 32'd0);
        step();
        i_req0_valid = 1'b0;
        wait_rdy(1'b1);
        step();
        i_req1_valid = 1'b0;
        wait_idle(1'b0);

        for (int i = 0; i < 8; i++) begin
            step();
            rp = 1'($urandom_range(0, 1));
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom | 32'd1;
            drv(rp, rop, ra, rb, 4'(i));
            wait_rdy(rp);
            step();
            if (!rp) i_req0_valid = 1'b0;
            else i_req1_valid = 1'b0;
            wait_idle(1'b1);
        end

        step();
        #3;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
